// File: rtl/qam_symbol_streamer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qam_symbol_streamer_pkg                                    |
// | Description : Shared types and constants for the QAM symbol streamer:    |
// |               the UART packet record exchanged with the deframer and     |
// |               framer, status codes, and the rx/tx/pacer state encodings. |
// | Ports       : none (package)                                             |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
package qam_symbol_streamer_pkg;

    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

    localparam logic [7:0] STATUS_XOFF = 8'hFF;
    localparam logic [7:0] STATUS_XON  = 8'h0F;

    // Receive packer states
    localparam logic       c_RX_WAIT   = 1'b0;
    localparam logic       c_RX_DATA   = 1'b1;

    // Symbol pacer states
    localparam logic       c_PACE_IDLE = 1'b0;
    localparam logic       c_PACE_BUSY = 1'b1;

    // Status transmitter states
    localparam logic [1:0] c_TX_IDLE   = 2'd0;
    localparam logic [1:0] c_TX_PEND   = 2'd1;
    localparam logic [1:0] c_TX_SEND   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/qam_symbol_streamer_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qam_symbol_streamer_sync_fifo                              |
// | Description : Single-clock show-ahead FIFO. The head word is always      |
// |               visible on opRdData; a written word is readable on the     |
// |               next clock. A simultaneous push and pop is accepted even   |
// |               when full, leaving the occupancy unchanged.                |
// | Ports       : ipClk, ipReset (async, active-high), ipWrEn/ipWrData push, |
// |               ipRdEn pop, opRdData head, opCount, opFull, opEmpty        |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
module qam_symbol_streamer_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int AW    = 12
) (
    input  logic             ipClk,
    input  logic             ipReset,
    input  logic             ipWrEn,
    input  logic [WIDTH-1:0] ipWrData,
    input  logic             ipRdEn,
    output logic [WIDTH-1:0] opRdData,
    output logic [AW:0]      opCount,
    output logic             opFull,
    output logic             opEmpty
);

    localparam int c_DEPTH = 2 ** AW;

    logic [WIDTH-1:0] r_mem [c_DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic             w_doWr;
    logic             w_doRd;

    // Count never exceeds the depth, so its MSB alone flags "full".
    assign opFull   = r_count[AW];
    assign opEmpty  = (r_count == '0);
    assign opCount  = r_count;
    assign opRdData = r_mem[r_rdPtr];

    assign w_doRd = ipRdEn & ~opEmpty;
    // When full, a push is only taken if the head leaves in the same clock;
    // the head has already been consumed combinationally, so reusing its slot is safe.
    assign w_doWr = ipWrEn & (~opFull | w_doRd);

    always_ff @(posedge ipClk) begin
        if (w_doWr) begin
            r_mem[r_wrPtr] <= ipWrData;
        end
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doWr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doRd) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doWr, w_doRd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/qam_symbol_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : qam_symbol_streamer                                        |
// | Description : Receives UART packets for DEST_ADDR, packs bytes LSB-first |
// |               into DATA_WIDTH words, buffers them and streams them out   |
// |               as SYMBOL_BITS symbols at a fast/slow symbol rate. Sends   |
// |               XOFF/XON status packets to the host with hysteresis.       |
// | Ports       : ipClk, ipReset (async, active-high), ipRxStream in,        |
// |               ipSlowMode, ipTxReady; opFIFO_Size, opStream(+Valid),      |
// |               opSymbol(+Valid), opOverflow, opUnderrun, opTxStream       |
// | Revision    : 1.0 - initial parametrised release                         |
// +--------------------------------------------------------------------------+
module qam_symbol_streamer
    import qam_symbol_streamer_pkg::*;
#(
    parameter int         DATA_WIDTH     = 16,
    parameter int         SYMBOL_BITS    = 4,
    parameter int         FIFO_AW        = 12,
    parameter int         HI_WATER       = 3840,
    parameter int         LO_WATER       = 1024,
    parameter int         FAST_PERIOD    = 567,
    parameter int         SLOW_PERIOD    = 5667,
    parameter int         STATUS_HOLDOFF = 25000000,
    parameter logic [7:0] DEST_ADDR      = 8'h10,
    parameter logic [7:0] HOST_ADDR      = 8'hAA
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  UART_PACKET             ipRxStream,
    input  logic                   ipSlowMode,
    output logic [FIFO_AW:0]       opFIFO_Size,
    output logic [DATA_WIDTH-1:0]  opStream,
    output logic                   opStreamValid,
    output logic [SYMBOL_BITS-1:0] opSymbol,
    output logic                   opSymbolValid,
    output logic                   opOverflow,
    output logic [15:0]            opUnderrun,
    output UART_PACKET             opTxStream,
    input  logic                   ipTxReady
);

    localparam int c_NBYTES  = DATA_WIDTH / 8;
    localparam int c_BYTE_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam int c_NSYM    = DATA_WIDTH / SYMBOL_BITS;
    localparam int c_SYM_W   = (c_NSYM > 1) ? $clog2(c_NSYM) : 1;
    localparam int c_PER_MAX = (FAST_PERIOD > SLOW_PERIOD) ? FAST_PERIOD : SLOW_PERIOD;
    localparam int c_PER_W   = $clog2(c_PER_MAX);
    localparam int c_HOLD_W  = (STATUS_HOLDOFF > 1) ? $clog2(STATUS_HOLDOFF) : 1;

    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(c_NBYTES - 1);
    localparam logic [c_SYM_W-1:0]  c_LAST_SYM  = c_SYM_W'(c_NSYM - 1);
    localparam logic [c_PER_W-1:0]  c_FAST_M1   = c_PER_W'(FAST_PERIOD - 1);
    localparam logic [c_PER_W-1:0]  c_SLOW_M1   = c_PER_W'(SLOW_PERIOD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_M1   = c_HOLD_W'(STATUS_HOLDOFF - 1);
    localparam logic [FIFO_AW:0]    c_HI        = (FIFO_AW + 1)'(HI_WATER);
    localparam logic [FIFO_AW:0]    c_LO        = (FIFO_AW + 1)'(LO_WATER);

    // Receive packer
    logic                   r_rxState;
    logic [c_BYTE_W-1:0]    r_byteCnt;
    logic [DATA_WIDTH-1:0]  r_assemble;
    logic                   r_wrEn;
    logic [DATA_WIDTH-1:0]  r_wrData;
    logic                   w_rxAccept;
    logic                   w_wordDone;
    logic [c_BYTE_W-1:0]    w_byteIdx;
    logic [DATA_WIDTH-1:0]  w_assembled;

    // FIFO
    logic [DATA_WIDTH-1:0]  w_fifoHead;
    logic [FIFO_AW:0]       w_fifoCount;
    logic                   w_fifoFull;
    logic                   w_fifoEmpty;

    // Symbol pacer
    logic                   r_paceState;
    logic                   r_slowMode;
    logic [c_PER_W-1:0]     r_periodCnt;
    logic [c_SYM_W-1:0]     r_symIdx;
    logic [DATA_WIDTH-1:0]  r_word;
    logic [DATA_WIDTH-1:0]  r_stream;
    logic                   r_streamValid;
    logic [SYMBOL_BITS-1:0] r_symbol;
    logic                   r_symValid;
    logic [15:0]            r_underrun;
    logic [c_PER_W-1:0]     w_periodM1;
    logic                   w_tick;
    logic                   w_retire;
    logic                   w_pop;
    logic [SYMBOL_BITS-1:0] w_curSym;

    // Status transmitter
    logic [1:0]             r_txState;
    logic [7:0]             r_code;
    logic [7:0]             r_lastCode;
    logic [c_HOLD_W-1:0]    r_holdoff;
    logic                   r_overflow;
    UART_PACKET             r_tx;
    logic                   w_ovfEvent;
    logic                   w_needXoff;
    logic                   w_needXon;

    // Header fields other than Destination are irrelevant to the receiver.
    logic w_unusedRx;
    assign w_unusedRx = &{1'b0, ipRxStream.Source, ipRxStream.Length};

    // ---------------------------------------------------------------- rx packer
    always_comb begin
        w_rxAccept  = ipRxStream.Valid &&
                      ((r_rxState == c_RX_DATA) ||
                       (ipRxStream.SoP && (ipRxStream.Destination == DEST_ADDR)));
        w_byteIdx   = (r_rxState == c_RX_WAIT) ? '0 : r_byteCnt;
        w_assembled = r_assemble;
        w_assembled[int'(w_byteIdx) * 8 +: 8] = ipRxStream.Data;
        w_wordDone  = w_rxAccept && (w_byteIdx == c_LAST_BYTE);
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_rxState  <= c_RX_WAIT;
            r_byteCnt  <= '0;
            r_assemble <= '0;
            r_wrEn     <= 1'b0;
            r_wrData   <= '0;
        end else begin
            r_wrEn <= w_wordDone;
            if (w_wordDone) begin
                r_wrData <= w_assembled;
            end
            if (w_rxAccept) begin
                r_assemble <= w_assembled;
                r_byteCnt  <= w_wordDone ? '0 : w_byteIdx + 1'b1;
                // A partial word left at EoP is simply abandoned.
                r_rxState  <= ipRxStream.EoP ? c_RX_WAIT : c_RX_DATA;
            end
        end
    end

    // --------------------------------------------------------------------- FIFO
    qam_symbol_streamer_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .ipClk    (ipClk),
        .ipReset  (ipReset),
        .ipWrEn   (r_wrEn),
        .ipWrData (r_wrData),
        .ipRdEn   (w_pop),
        .opRdData (w_fifoHead),
        .opCount  (w_fifoCount),
        .opFull   (w_fifoFull),
        .opEmpty  (w_fifoEmpty)
    );

    // ------------------------------------------------------------- symbol pacer
    always_comb begin
        w_periodM1 = r_slowMode ? c_SLOW_M1 : c_FAST_M1;
        // '>=' so a switch to a shorter period cannot strand the counter past its end.
        w_tick     = (r_periodCnt >= w_periodM1);
        w_retire   = (r_paceState == c_PACE_BUSY) && w_tick && (r_symIdx == c_LAST_SYM);
        w_pop      = ~w_fifoEmpty && ((r_paceState == c_PACE_IDLE) || w_retire);
        w_curSym   = r_word[int'(r_symIdx) * SYMBOL_BITS +: SYMBOL_BITS];
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_paceState   <= c_PACE_IDLE;
            r_slowMode    <= 1'b0;
            r_periodCnt   <= '0;
            r_symIdx      <= '0;
            r_word        <= '0;
            r_stream      <= '0;
            r_streamValid <= 1'b0;
            r_symbol      <= '0;
            r_symValid    <= 1'b0;
            r_underrun    <= '0;
        end else begin
            r_periodCnt   <= w_tick ? '0 : r_periodCnt + 1'b1;
            r_symValid    <= 1'b0;
            r_streamValid <= 1'b0;

            // Rate only changes between words.
            if ((r_paceState == c_PACE_IDLE) || w_retire) begin
                r_slowMode <= ipSlowMode;
            end

            if (w_tick) begin
                if (r_paceState == c_PACE_BUSY) begin
                    r_symbol   <= w_curSym;
                    r_symValid <= 1'b1;
                    r_stream   <= r_word;
                    if (r_symIdx == c_LAST_SYM) begin
                        r_streamValid <= 1'b1;
                        r_symIdx      <= '0;
                    end else begin
                        r_symIdx <= r_symIdx + 1'b1;
                    end
                end else if (r_underrun != 16'hFFFF) begin
                    r_underrun <= r_underrun + 16'd1;
                end
            end

            if (w_pop) begin
                r_word      <= w_fifoHead;
                r_paceState <= c_PACE_BUSY;
            end else if (w_retire) begin
                r_paceState <= c_PACE_IDLE;
            end
        end
    end

    // -------------------------------------------------------- status transmitter
    always_comb begin
        w_ovfEvent = r_wrEn && w_fifoFull && ~w_pop;
        // Keying on the last code sent gives the hysteresis and prevents repeats.
        w_needXoff = ((w_fifoCount >= c_HI) || w_ovfEvent) && (r_lastCode != STATUS_XOFF);
        w_needXon  = (r_lastCode == STATUS_XOFF) && (w_fifoCount <= c_LO);
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            r_txState          <= c_TX_IDLE;
            r_code             <= '0;
            r_lastCode         <= '0;
            r_holdoff          <= '0;
            r_overflow         <= 1'b0;
            r_tx               <= '0;
            r_tx.Source        <= DEST_ADDR;
            r_tx.Destination   <= HOST_ADDR;
        end else begin
            if (w_ovfEvent) begin
                r_overflow <= 1'b1;
            end
            if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end

            case (r_txState)
                c_TX_IDLE: begin
                    if (w_needXoff) begin
                        r_code     <= STATUS_XOFF;
                        r_lastCode <= STATUS_XOFF;
                        r_txState  <= c_TX_PEND;
                    end else if (w_needXon) begin
                        r_code     <= STATUS_XON;
                        r_lastCode <= STATUS_XON;
                        r_txState  <= c_TX_PEND;
                    end
                end
                c_TX_PEND: begin
                    if ((r_holdoff == '0) && ipTxReady) begin
                        r_tx.Valid  <= 1'b1;
                        r_tx.SoP    <= 1'b1;
                        r_tx.EoP    <= 1'b1;
                        r_tx.Length <= 8'd1;
                        r_tx.Data   <= r_code;
                        // Loaded with PERIOD-1 so the next send lands exactly HOLDOFF clocks later.
                        r_holdoff   <= c_HOLD_M1;
                        r_txState   <= c_TX_SEND;
                    end
                end
                c_TX_SEND: begin
                    r_tx.Valid  <= 1'b0;
                    r_tx.SoP    <= 1'b0;
                    r_tx.EoP    <= 1'b0;
                    r_tx.Length <= 8'd0;
                    r_tx.Data   <= 8'd0;
                    r_txState   <= c_TX_IDLE;
                end
                default: r_txState <= c_TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ outputs
    assign opFIFO_Size   = w_fifoCount;
    assign opStream      = r_stream;
    assign opStreamValid = r_streamValid;
    assign opSymbol      = r_symbol;
    assign opSymbolValid = r_symValid;
    assign opOverflow    = r_overflow;
    assign opUnderrun    = r_underrun;
    assign opTxStream    = r_tx;

endmodule
`default_nettype wire
